// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART byte receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int CLKS_PER_BIT_DEF = 10417;

    // Width that holds 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with a parameterised reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic clr,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - mid-bit sampling 8N1 UART receiver (even parity with UART_RX_PARITY_EN)
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 parity_err
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int IDX_W = cnt_width(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q;
    logic                 parity_err_q;
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .clr (clr),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q              <= '0;
                        shreg_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q     <= '0;
                        par_bad_q <= rx_s ^ (^shreg_q);
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                data_q  <= shreg_q;
                                valid_q <= 1'b1;
                            end
`else
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
`endif
                        end else begin
                            // A low stop bit means a break or misframe; wait for idle.
                            state_q     <= BREAK;
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - directed table-driven bench for uart_rx_byte at 16 clocks per bit
module tb_uart_rx_byte;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * CPB;
    // Mid stop bit, plus two synchronizer flops, plus the registered strobe.
    localparam int LAT = (FRAME_BITS - 1) * CPB + CPB / 2 + 3;

    logic       clk = 1'b0;
    logic       clr;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic       parity_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int vcnt = 0, fcnt = 0, pcnt = 0;
    int vtime = 0;
    int wide = 0, overlap = 0;
    logic pv = 1'b0, pf = 1'b0, pp = 1'b0;
    int start_cyc = 0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_data;
        int         gap;
    } vec_t;

    vec_t tbl [4];

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcnt  = vcnt + 1;
            vtime = cyc;
        end
        if (frame_err) fcnt = fcnt + 1;
        if (parity_err) pcnt = pcnt + 1;
        if ((valid && pv) || (frame_err && pf) || (parity_err && pp)) wide = wide + 1;
        if ((int'(valid) + int'(frame_err) + int'(parity_err)) > 1) overlap = overlap + 1;
        pv = valid;
        pf = frame_err;
        pp = parity_err;
    end

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_b);
    endtask

    initial begin
        int v0, f0, prev_vt, sp;

        tbl[0] = '{data: 8'hA5, exp_data: 8'hA5, gap: 20};
        tbl[1] = '{data: 8'h00, exp_data: 8'h00, gap: 0};
        tbl[2] = '{data: 8'hFF, exp_data: 8'hFF, gap: 0};
        tbl[3] = '{data: 8'h3C, exp_data: 8'h3C, gap: 20};

        clr = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", int'(data_out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_perr", int'(parity_err), 0);
        check("rst_busy", int'(busy), 0);
        clr = 1'b0;
        idle_cycles(5);

        // Abort a frame with clr in the middle of data bit 3.
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        check("midrst_busy_before", int'(busy), 1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check("midrst_idle", int'(busy), 0);
        idle_cycles(200);
        check("midrst_no_valid", vcnt, 0);
        check("midrst_still_idle", int'(busy), 0);

        prev_vt = 0;
        for (int i = 0; i < 4; i++) begin
            v0 = vcnt;
            f0 = fcnt;
            send_frame(tbl[i].data, 1'b1);
            check($sformatf("vec%0d_valid_cnt", i), vcnt, v0 + 1);
            check($sformatf("vec%0d_data", i), int'(data_out), int'(tbl[i].exp_data));
            check($sformatf("vec%0d_ferr", i), fcnt, f0);
            check($sformatf("vec%0d_latency", i), vtime - start_cyc, LAT);
            check($sformatf("vec%0d_busy_after", i), int'(busy), 0);
            if (i > 0 && tbl[i-1].gap == 0) begin
                sp = vtime - prev_vt;
                check($sformatf("vec%0d_spacing", i),
                      int'(sp >= FRAME_CLKS - 2 && sp <= FRAME_CLKS + 2), 1);
            end
            prev_vt = vtime;
            idle_cycles(tbl[i].gap);
        end

        // False start: 5-clock low glitch.
        v0 = vcnt;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        check("glitch_busy", int'(busy), 1);
        repeat (9) @(posedge clk);
        #1;
        check("glitch_idle", int'(busy), 0);
        idle_cycles(20);
        check("glitch_no_valid", vcnt, v0);
        send_frame(8'h5A, 1'b1);
        check("after_glitch_valid", vcnt, v0 + 1);
        check("after_glitch_data", int'(data_out), 8'h5A);
        idle_cycles(10);

        // Low stop bit with the line held low afterwards.
        v0 = vcnt;
        f0 = fcnt;
        send_frame(8'h81, 1'b0);
        rx = 1'b0;
        repeat (40 - CPB) @(posedge clk);
        #1;
        check("ferr_cnt", fcnt, f0 + 1);
        check("ferr_no_valid", vcnt, v0);
        check("ferr_data_hold", int'(data_out), 8'h5A);
        check("ferr_break_busy", int'(busy), 1);
        idle_cycles(20);
        check("ferr_release_idle", int'(busy), 0);
        check("ferr_no_retrigger", fcnt, f0 + 1);
        send_frame(8'h42, 1'b1);
        check("after_ferr_valid", vcnt, v0 + 1);
        check("after_ferr_data", int'(data_out), 8'h42);
        idle_cycles(10);

`ifdef UART_RX_PARITY_EN
        v0 = vcnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        check("par_bad_perr", pcnt, 1);
        check("par_bad_no_valid", vcnt, v0);
        check("par_bad_data_hold", int'(data_out), 8'h42);
        idle_cycles(10);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        check("par_good_valid", vcnt, v0 + 1);
        check("par_good_data", int'(data_out), 8'h07);
        check("par_good_no_perr", pcnt, 1);
        idle_cycles(10);
`else
        check("perr_never", pcnt, 0);
`endif

        check("pulse_width", wide, 0);
        check("pulse_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
